// File: rtl/core_pkg.sv
// Shared definitions for the core instruction sequencer: instruction word layout,
// the idle instruction word and the sequencer state encoding.
package core_pkg;

  localparam int INST_W       = 34;
  localparam int ADDR_FIELD_W = 11;

  localparam int B_ACC      = 33;
  localparam int B_CEN_PMEM = 32;
  localparam int B_WEN_PMEM = 31;
  localparam int A_PMEM_LSB = 20;
  localparam int B_CEN_XMEM = 19;
  localparam int B_WEN_XMEM = 18;
  localparam int A_XMEM_LSB = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXECUTE  = 1;
  localparam int B_LOAD     = 0;

  // Both memories deselected and write-disabled, every strobe low.
  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_W_FILL = 3'd1,
    S_W_LOAD = 3'd2,
    S_A_FILL = 3'd3,
    S_EXEC   = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/seq_addr_gen.sv
// Address register for the sequencer: reloads from a base value or steps by one,
// wrapping silently at the address width.
module seq_addr_gen #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] addr
);

  logic [W-1:0] addr_r;

  // Reload has priority over stepping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r <= '0;
    end else if (load) begin
      addr_r <= load_val;
    end else if (inc) begin
      addr_r <= addr_r + W'(1);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign addr = addr_r;

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer: runs one weight-stationary convolution pass per accepted start,
// emitting a registered 34-bit core instruction word every cycle.
module core_inst_seq
  import core_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int len_w  = 8,
  parameter int kij_w  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [kij_w-1:0]  n_kij,
  input  logic [len_w-1:0]  act_len,
  input  logic [addr_w-1:0] x_w_base,
  input  logic [addr_w-1:0] x_a_base,
  input  logic [addr_w-1:0] p_base,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = len_w + 2;

  state_t            state_r;
  state_t            adv_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [kij_w-1:0]  kij_r;
  logic [kij_w-1:0]  n_kij_r;
  logic [len_w-1:0]  act_len_r;
  logic [addr_w-1:0] a_base_r;
  logic [addr_w-1:0] w_addr_s;
  logic [addr_w-1:0] a_addr_s;
  logic [addr_w-1:0] p_addr_s;
  logic [CNT_W-1:0]  len_s;
  logic              accept_s;
  logic              w_rd_s;
  logic              a_rd_s;
  logic              p_wr_s;
  logic              last_s;
  logic [INST_W-1:0] inst_s;
  logic [INST_W-1:0] inst_r;
  logic              busy_r;
  logic              done_r;

  assign len_s    = CNT_W'(act_len_r);
  assign accept_s = (state_r == S_IDLE) && start;
  assign w_rd_s   = (state_r == S_W_FILL) && (cnt_r < CNT_W'(row));
  assign a_rd_s   = (state_r == S_A_FILL) && (cnt_r < len_s);
  assign p_wr_s   = (state_r == S_DRAIN) && (cnt_r < len_s) && ofifo_valid;

  // Weight and psum addresses are contiguous across kij, so they only step;
  // the activation pointer is reloaded while the PE array takes its weights.
  seq_addr_gen #(.W(addr_w)) u_w_addr (
    .clk(clk), .reset(reset), .load(accept_s), .inc(w_rd_s),
    .load_val(x_w_base), .addr(w_addr_s)
  );
  seq_addr_gen #(.W(addr_w)) u_a_addr (
    .clk(clk), .reset(reset), .load(state_r == S_W_LOAD), .inc(a_rd_s),
    .load_val(a_base_r), .addr(a_addr_s)
  );
  seq_addr_gen #(.W(addr_w)) u_p_addr (
    .clk(clk), .reset(reset), .load(accept_s), .inc(p_wr_s),
    .load_val(p_base), .addr(p_addr_s)
  );

  // Last cycle of each fixed-length state and the state that follows it
  always_comb begin
    last_s = 1'b0;
    adv_s  = S_IDLE;
    case (state_r)
      S_W_FILL: begin last_s = (cnt_r == CNT_W'(row));                 adv_s = S_W_LOAD; end
      S_W_LOAD: begin last_s = (cnt_r == CNT_W'(row + col - 1));       adv_s = S_A_FILL; end
      S_A_FILL: begin last_s = (cnt_r == len_s);                       adv_s = S_EXEC;   end
      S_EXEC:   begin last_s = (cnt_r == len_s + CNT_W'(row + col - 1)); adv_s = S_DRAIN; end
      S_DRAIN:  begin last_s = (cnt_r == len_s);                       adv_s = S_DONE;   end
      default:  begin last_s = 1'b0;                                   adv_s = S_IDLE;   end
    endcase
  end

  // Instruction word for the current state cycle; fill-state L0 writes trail the SRAM read by one
  always_comb begin
    inst_s             = IDLE_INST;
    inst_s[B_ACC]      = 1'b0;
    inst_s[B_IFIFO_WR] = 1'b0;
    inst_s[B_IFIFO_RD] = 1'b0;
    case (state_r)
      S_W_FILL: begin
        inst_s[B_CEN_XMEM] = ~w_rd_s;
        inst_s[A_XMEM_LSB +: ADDR_FIELD_W] = w_rd_s ? ADDR_FIELD_W'(w_addr_s) : 11'd0;
        inst_s[B_L0_WR]    = (cnt_r != '0);
      end
      S_W_LOAD: begin
        inst_s[B_L0_RD] = (cnt_r < CNT_W'(row));
        inst_s[B_LOAD]  = 1'b1;
      end
      S_A_FILL: begin
        inst_s[B_CEN_XMEM] = ~a_rd_s;
        inst_s[A_XMEM_LSB +: ADDR_FIELD_W] = a_rd_s ? ADDR_FIELD_W'(a_addr_s) : 11'd0;
        inst_s[B_L0_WR]    = (cnt_r != '0);
      end
      S_EXEC: begin
        inst_s[B_L0_RD]   = (cnt_r < len_s);
        inst_s[B_EXECUTE] = 1'b1;
      end
      S_DRAIN: begin
        inst_s[B_OFIFO_RD] = p_wr_s;
        inst_s[B_CEN_PMEM] = ~p_wr_s;
        inst_s[B_WEN_PMEM] = ~p_wr_s;
        inst_s[A_PMEM_LSB +: ADDR_FIELD_W] = p_wr_s ? ADDR_FIELD_W'(p_addr_s) : 11'd0;
      end
      default: inst_s = IDLE_INST;
    endcase
  end

  // Pass sequencing: state, per-state cycle counter, kij progress and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      kij_r     <= '0;
      n_kij_r   <= '0;
      act_len_r <= '0;
      a_base_r  <= '0;
      inst_r    <= IDLE_INST;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      inst_r <= inst_s;
      busy_r <= (state_r != S_IDLE);
      done_r <= (state_r == S_DONE);
      case (state_r)
        S_IDLE: begin
          cnt_r <= '0;
          kij_r <= '0;
          if (start) begin
            n_kij_r   <= n_kij;
            act_len_r <= act_len;
            a_base_r  <= x_a_base;
            state_r   <= ((n_kij == '0) || (act_len == '0)) ? S_DONE : S_W_FILL;
          end
        end
        S_DRAIN: begin
          if (last_s) begin
            cnt_r   <= '0;
            kij_r   <= kij_r + kij_w'(1);
            state_r <= ((kij_r + kij_w'(1)) == n_kij_r) ? S_DONE : S_W_FILL;
          end else if (p_wr_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_DONE: begin
          cnt_r   <= '0;
          state_r <= S_IDLE;
        end
        default: begin
          if (last_s) begin
            cnt_r   <= '0;
            state_r <= adv_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign inst = inst_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed self-checking bench for core_inst_seq: records the instruction stream of
// each pass and compares addresses, strobe counts and timing with hand-derived values.
module tb_core_inst_seq;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [3:0]  n_kij;
  logic [7:0]  act_len;
  logic [10:0] x_w_base, x_a_base, p_base;
  logic [33:0] inst;
  logic        busy, done;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] xq[$];
  logic [10:0] pq[$];
  int n_busy, n_done, done_at, n_l0wr, n_l0rd, n_load, n_exec, n_ordd, n_bad;

  core_inst_seq dut (
    .clk(clk), .reset(reset), .start(start), .n_kij(n_kij), .act_len(act_len),
    .x_w_base(x_w_base), .x_a_base(x_a_base), .p_base(p_base),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record one instruction word; vprev is the ofifo_valid seen by the cycle that produced it
  task automatic sample(input logic vprev);
    if (busy) n_busy++;
    if (done) n_done++;
    if (!inst[19]) xq.push_back(inst[17:7]);
    if (!inst[32]) pq.push_back(inst[30:20]);
    n_l0wr += int'(inst[2]);
    n_l0rd += int'(inst[3]);
    n_load += int'(inst[0]);
    n_exec += int'(inst[1]);
    n_ordd += int'(inst[6]);
    if (inst[33] || inst[5] || inst[4] || !inst[18]) n_bad++;
    if ((inst[6] != !inst[32]) || (inst[31] != inst[32]) || (inst[6] && !vprev)) n_bad++;
  endtask

  task automatic do_pass(input logic [3:0] nk, input logic [7:0] al, input logic [10:0] wb,
                         input logic [10:0] ab, input logic [10:0] pb, input bit toggle,
                         input bit glitch);
    int c;
    logic v;
    xq.delete(); pq.delete();
    n_busy = 0; n_done = 0; done_at = -1;
    n_l0wr = 0; n_l0rd = 0; n_load = 0; n_exec = 0; n_ordd = 0; n_bad = 0;
    n_kij = nk; act_len = al; x_w_base = wb; x_a_base = ab; p_base = pb;
    ofifo_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (c < 400 && !(done_at >= 0 && c > done_at)) begin
      c++;
      v = toggle ? ((c % 3) == 0) : 1'b1;
      ofifo_valid = v;
      start = glitch && (c == 20);
      if (glitch && c == 20) begin
        n_kij = 4'd7; act_len = 8'd1; x_w_base = 11'd500; x_a_base = 11'd600; p_base = 11'd700;
      end
      tick();
      sample(v);
      if (done && done_at < 0) done_at = c;
    end
    start = 1'b0;
    check("pass_terminates", done_at >= 0, 1'b1);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic check_pass(input int nk, input int al, input logic [10:0] wb,
                            input logic [10:0] ab, input logic [10:0] pb, input int exp_cycles);
    int ke;
    logic [10:0] e;
    ke = (al == 0) ? 0 : nk;
    check("xmem_read_count", xq.size(), ke * (8 + al));
    check("pmem_write_count", pq.size(), ke * al);
    for (int k = 0; k < ke; k++) begin
      for (int i = 0; i < 8; i++) begin
        e = wb + 11'(k * 8 + i);
        if (k * (8 + al) + i < xq.size()) check("w_addr", xq[k * (8 + al) + i], e);
      end
      for (int j = 0; j < al; j++) begin
        e = ab + 11'(j);
        if (k * (8 + al) + 8 + j < xq.size()) check("a_addr", xq[k * (8 + al) + 8 + j], e);
        e = pb + 11'(k * al + j);
        if (k * al + j < pq.size()) check("p_addr", pq[k * al + j], e);
      end
    end
    check("done_pulses", n_done, 1);
    if (exp_cycles >= 0) begin
      check("done_cycle", done_at, exp_cycles);
      check("busy_cycles", n_busy, exp_cycles);
    end
    check("l0_wr_count", n_l0wr, ke * (8 + al));
    check("l0_rd_count", n_l0rd, ke * (8 + al));
    check("load_count", n_load, ke * 16);
    check("exec_count", n_exec, ke * (al + 16));
    check("ofifo_rd_count", n_ordd, ke * al);
    check("word_format", n_bad, 0);
  endtask

  initial begin
    int c, ex;
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
    n_kij = 4'd0; act_len = 8'd0; x_w_base = 11'd0; x_a_base = 11'd0; p_base = 11'd0;
    repeat (3) tick();
    check("rst_inst", inst, IDLE_W);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("idle_inst", inst, IDLE_W);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
    end

    // single kij: weights 0..7, activations 16..19, psums 0..3, 55 cycles + DONE
    do_pass(4'd1, 8'd4, 11'd0, 11'd16, 11'd0, 1'b0, 1'b0);
    check_pass(1, 4, 11'd0, 11'd16, 11'd0, 56);
    // two kij with an ignored start and config change mid-pass
    do_pass(4'd2, 8'd4, 11'd0, 11'd16, 11'd100, 1'b0, 1'b1);
    check_pass(2, 4, 11'd0, 11'd16, 11'd100, 111);
    // OFIFO valid 1,0,0,1,... during drain
    do_pass(4'd1, 8'd4, 11'd0, 11'd16, 11'd0, 1'b1, 1'b0);
    check_pass(1, 4, 11'd0, 11'd16, 11'd0, -1);
    // activation addresses wrap 2046,2047,0,1
    do_pass(4'd1, 8'd4, 11'd0, 11'd2046, 11'd0, 1'b0, 1'b0);
    check_pass(1, 4, 11'd0, 11'd2046, 11'd0, 56);
    check("wrap_addr_2", xq[10], 11'd0);
    // empty passes
    do_pass(4'd1, 8'd0, 11'd0, 11'd16, 11'd0, 1'b0, 1'b0);
    check_pass(1, 0, 11'd0, 11'd16, 11'd0, 1);
    do_pass(4'd0, 8'd4, 11'd0, 11'd16, 11'd0, 1'b0, 1'b0);
    check_pass(0, 4, 11'd0, 11'd16, 11'd0, 1);

    // reset asserted during EXEC
    n_kij = 4'd1; act_len = 8'd4; x_w_base = 11'd0; x_a_base = 11'd16; p_base = 11'd0;
    ofifo_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0; ex = 0;
    while (ex < 3 && c < 200) begin
      tick();
      c++;
      if (inst[1]) ex++;
    end
    check("reach_exec", ex, 3);
    reset = 1'b1;
    #1;
    check("midrst_inst", inst, IDLE_W);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) n_done++;
    end
    check("no_done_after_rst", n_done, 0);
    check("idle_after_rst", inst, IDLE_W);
    do_pass(4'd1, 8'd4, 11'd0, 11'd16, 11'd0, 1'b0, 1'b0);
    check_pass(1, 4, 11'd0, 11'd16, 11'd0, 56);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
